// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: assembles a big-endian byte stream (16-bit word count, then words) into IMEM writes, then soft-resets and powers the CPU.
// Latency: writeI one cycle after the 4th byte of a word; 5 cycles per word at full rate; softReset RST_CYCLES, then power.
// Backpressure: rx_ready is a registered state decode, low during WRITE/RST/RUN/ERR/IDLE; rx_valid low stalls indefinitely.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MAX_WORDS  = 256,
    parameter int RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        writeI,
    output logic [31:0] dataI,
    output logic [31:0] TPC,
    output logic        softReset,
    output logic        power,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_BYTES,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RST,
        S_RUN,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     bcnt_q, bcnt_d;
    logic [15:0]    wcnt_q, wcnt_d;
    logic [31:0]    data_q, data_d;
    logic [31:0]    tpc_q, tpc_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           rx_ready_q, writei_q, srst_q, power_q, busy_q, done_q, err_q;
    logic           accept;
    logic [15:0]    n_words;
    // State after all words are written (or immediately for an empty image).
    state_t         after_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
    assign after_words = S_CHK;
`else
    assign after_words = S_RST;
`endif

    assign accept  = rx_valid && rx_ready_q;
    assign n_words = {wcnt_q[15:8], rx_data};

    // Next-state and datapath update; start overrides everything, including a same-cycle byte.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        tpc_d   = tpc_q;
        rcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (start) begin
            state_d = S_CNT_HI;
            bcnt_d  = 2'd0;
            wcnt_d  = 16'd0;
            tpc_d   = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept && state_q != S_CHK) csum_d = csum_q ^ rx_data;
`endif
            case (state_q)
                S_CNT_HI: if (accept) begin
                    wcnt_d  = {rx_data, 8'h00};
                    state_d = S_CNT_LO;
                end
                S_CNT_LO: if (accept) begin
                    wcnt_d = n_words;
                    if ({1'b0, n_words} > MAX_W) state_d = S_ERR;
                    else if (n_words == 16'd0)   state_d = after_words;
                    else                         state_d = S_BYTES;
                end
                S_BYTES: if (accept) begin
                    data_d = {data_q[23:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = S_WRITE;
                end
                S_WRITE: begin
                    tpc_d   = tpc_q + 32'd4;
                    wcnt_d  = wcnt_q - 16'd1;
                    state_d = (wcnt_q == 16'd1) ? after_words : S_BYTES;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: if (accept) begin
                    state_d = (rx_data == csum_q) ? S_RST : S_ERR;
                end
`endif
                S_RST: begin
                    if (rcnt_q == RST_LAST) state_d = S_RUN;
                    else                    rcnt_d  = rcnt_q + RCW'(1);
                end
                default: ;
            endcase
        end
    end

    // State, datapath and registered output flags (decoded from the next state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bcnt_q     <= '0;
            wcnt_q     <= '0;
            data_q     <= '0;
            tpc_q      <= '0;
            rcnt_q     <= '0;
            rx_ready_q <= 1'b0;
            writei_q   <= 1'b0;
            srst_q     <= 1'b0;
            power_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            wcnt_q     <= wcnt_d;
            data_q     <= data_d;
            tpc_q      <= tpc_d;
            rcnt_q     <= rcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            rx_ready_q <= state_d inside {S_CNT_HI, S_CNT_LO, S_BYTES, S_CHK};
`else
            rx_ready_q <= state_d inside {S_CNT_HI, S_CNT_LO, S_BYTES};
`endif
            writei_q   <= (state_d == S_WRITE);
            srst_q     <= (state_d == S_RST);
            power_q    <= (state_d == S_RUN);
            busy_q     <= !(state_d inside {S_IDLE, S_RUN, S_ERR});
            done_q     <= (state_d == S_RUN);
            err_q      <= (state_d == S_ERR);
        end
    end

    assign rx_ready  = rx_ready_q;
    assign writeI    = writei_q;
    assign dataI     = data_q;
    assign TPC       = tpc_q;
    assign softReset = srst_q;
    assign power     = power_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Upstream program loader for `CPUtop`. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into instruction memory through the `writeI`/`dataI`/`TPC` port. After the last word it pulses `softReset` and then raises `power` to start execution.

## Interface
Parameters:
- `MAX_WORDS`, default 256: maximum image size in words. A header count above this is an error.
- `RST_CYCLES`, default 2: length of the `softReset` pulse, in clocks (≥1).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins (or restarts) a load.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte. A byte transfers when `rx_valid && rx_ready`.
- `writeI`  out  1  IMEM write strobe.
- `dataI`  out  32  IMEM write data.
- `TPC`  out  32  IMEM write byte address.
- `softReset`  out  1  CPU soft reset.
- `power`  out  1  CPU run enable.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky: load completed successfully.
- `err`  out  1  sticky: load aborted.

## Operation
- Stream format: count_hi, count_lo (16-bit word count N), then 4·N bytes, MSB first per word.
- States and transitions:
  - IDLE → CNT_HI on `start`.
  - CNT_HI → CNT_LO after one byte.
  - CNT_LO → then one of:
    - ERR if N > `MAX_WORDS`;
    - RST if N = 0;
    - otherwise BYTES.
  - BYTES → WRITE after the 4th byte of a word.
  - WRITE → BYTES if words remain; otherwise RST (or CHK when checksum is enabled).
  - RST → RUN after `RST_CYCLES` cycles.
  - RUN and ERR hold until the next `start`.
- Outputs per state:
  - `rx_ready`: 1 only in CNT_HI, CNT_LO, BYTES and CHK.
  - `busy`: 1 in every state except IDLE, RUN and ERR.
- `start` in any state:
  - forces CNT_HI;
  - clears `power`, `done`, `err`, the byte counter and the word counter;
  - sets `TPC` to 0.
- Byte assembly: `dataI <= {dataI[23:0], rx_data}` on each accepted byte in BYTES. A 2-bit byte counter wraps after 3.
- WRITE: `writeI` = 1 for exactly one cycle, with `dataI`/`TPC` holding the assembled word and its address. On exit, `TPC <= TPC + 4` (32-bit, wraps modulo 2^32).
- The word counter is 16-bit and counts down from N. The loader finishes when it reaches 0.
- RST: `softReset` = 1 and `power` = 0.
- RUN:
  - `softReset` = 0, `power` = 1, `done` = 1;
  - `TPC` keeps its final value (4·N).
- ERR: `err` = 1, `power` = 0, `softReset` = 0, `writeI` = 0.

## Timing
- Reset values:
  - state IDLE;
  - `rx_ready`, `writeI`, `softReset`, `power`, `busy`, `done`, `err` all 0;
  - `dataI` = 0, `TPC` = 0.
- Outputs are registered, with no combinational path from `rx_valid` to `rx_ready`.
- Word write: `writeI` is high in the cycle after the 4th byte is accepted. Minimum of 5 cycles per word at full stream rate.
- `rx_ready` is 0 during WRITE, so there is one bubble per word.
- `rx_valid` low stalls the loader indefinitely with no timeout. State and counters hold.
- `start` and a byte transfer in the same cycle: `start` wins and the byte is dropped.
- `reset` asserted mid-load: everything returns immediately to reset values. Partially written IMEM contents are left as they are.
- The last write precedes `softReset` by ≥1 cycle. `power` rises in the cycle after `softReset` falls.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - after the last word, CHK accepts one extra byte;
  - equal to the XOR of all preceding stream bytes (count included) → RST;
  - not equal → ERR.
  - With N = 0, the checksum byte follows the count.
- Undefined: no CHK state; WRITE of the last word (or N = 0) goes straight to RST.

## Test plan
- Load N=2 with words 0x20000000, 0x20010014:
  - `writeI` fires twice, at `TPC` 0 then 4, with the matching data;
  - then `softReset` lasts 2 cycles, then `power`=1, `done`=1, `TPC`=8.
- Stream with random `rx_valid` gaps, N=3: same three writes and addresses as at full rate, and `writeI` pulses exactly 3 times.
- Header count `MAX_WORDS`+1 (257): ERR, `err`=1, no `writeI`, `power` stays 0.
- Reset (low) after 2 bytes of word 1: all outputs return to reset values. A new `start` plus a full stream then loads correctly from `TPC`=0.
- `start` pulse in RUN:
  - `power` drops the next cycle and `done` clears;
  - then N=0 gives `softReset` then `power` with no writes.
- With `IMEM_LOADER_CHECKSUM_EN`:
  - correct XOR byte → RUN;
  - corrupted checksum byte → `err`=1 and `power`=0, after the last write has already occurred.
